// File: rtl/bram32k_wr_arb_pkg.sv
// Shared constants for the 32k activation BRAM write-port arbiter.
package bram32k_wr_arb_pkg;

  // Arbiter states. The owner states are one-hot so they double as the
  // external owner bus (01 = requester 0, 10 = requester 1, 00 = idle).
  localparam logic [1:0] ArbIdle = 2'b00;
  localparam logic [1:0] ArbOwn0 = 2'b01;
  localparam logic [1:0] ArbOwn1 = 2'b10;

  // Default burst cap and mid-burst stall tolerance.
  localparam int BurstMaxDef = 8;
  localparam int HoldMaxDef  = 4;

endpackage

// File: rtl/wr_arb_burst_ctr.sv
// Burst beat counter and owner-stall counter for the write arbiter.
// Flags the end of the current grant: last beat, beat cap, or stall timeout.
module wr_arb_burst_ctr
  import bram32k_wr_arb_pkg::*;
#(
  parameter int BURST_MAX = BurstMaxDef,
  parameter int HOLD_MAX  = HoldMaxDef
) (
  input  logic clk,
  input  logic rst,
  input  logic xfer,         // beat accepted this cycle
  input  logic last,         // accepted beat is flagged last
  input  logic owned,        // arbiter is in an owner state
  input  logic owner_valid,  // current owner offers a beat
  output logic burst_end,
  output logic hold_expire
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          cap_hit;

  // Next-count logic; both counters clear whenever a grant ends.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    cap_hit     = xfer && (burst_cnt_q == BW'(BURST_MAX - 1));
    hold_expire = owned && !owner_valid && (hold_cnt_q == HW'(HOLD_MAX - 1));
    // last and cap in the same beat still form one burst end
    burst_end   = (xfer && (last || cap_hit)) || hold_expire;
    if (burst_end) begin
      burst_cnt_d = '0;
      hold_cnt_d  = '0;
    end else begin
      if (xfer) burst_cnt_d = burst_cnt_q + BW'(1);
      if (!owned || owner_valid) hold_cnt_d = '0;
      else                       hold_cnt_d = hold_cnt_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/bram32k_wr_arb.sv
// Write-port arbiter for the 32k activation BRAM pair. Grants whole bursts
// round-robin between the conv writeback packer (s0) and the layer-5
// channel-buffer drain (s1); every BRAM-facing signal is registered.
module bram32k_wr_arb
  import bram32k_wr_arb_pkg::*;
#(
  parameter int AW        = 12,
  parameter int DW        = 64,
  parameter int BURST_MAX = BurstMaxDef,
  parameter int HOLD_MAX  = HoldMaxDef
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic          s0_last,
  input  logic [AW-1:0] s0_addr1,
  input  logic [AW-1:0] s0_addr2,
  input  logic [DW-1:0] s0_din1,
  input  logic [DW-1:0] s0_din2,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic          s1_last,
  input  logic [AW-1:0] s1_addr1,
  input  logic [AW-1:0] s1_addr2,
  input  logic [DW-1:0] s1_din1,
  input  logic [DW-1:0] s1_din2,
  output logic          we_BRAM32k,
  output logic [AW-1:0] addr_BRAM32k_1,
  output logic [AW-1:0] addr_BRAM32k_2,
  output logic [DW-1:0] din_BRAM32k_1,
  output logic [DW-1:0] din_BRAM32k_2,
  output logic [1:0]    owner,
  output logic          collision_err,
  output logic [15:0]   beats0,
  output logic [15:0]   beats1
);

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DW-1:0] din1_q, din1_d, din2_q, din2_d;
  logic          coll_q, coll_d;
  logic [15:0]   beats0_q, beats0_d, beats1_q, beats1_d;

  logic          xfer0, xfer1, xfer, sel1, win_last, owned, owner_valid;
  logic          burst_end, hold_expire;
  logic [AW-1:0] win_addr1, win_addr2;
  logic [DW-1:0] win_din1, win_din2;

  // Ready generation: owner states lock the grant, idle arbitrates
  // combinationally so a new burst starts with no bubble.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        ArbOwn0: s0_ready = 1'b1;
        ArbOwn1: s1_ready = 1'b1;
        default: begin
          if (s0_valid && (!s1_valid || !rr_q)) s0_ready = 1'b1;
          else if (s1_valid)                    s1_ready = 1'b1;
        end
      endcase
    end
  end

  assign xfer0       = s0_valid && s0_ready;
  assign xfer1       = s1_valid && s1_ready;
  assign xfer        = xfer0 || xfer1;
  assign sel1        = s1_ready;
  assign win_last    = sel1 ? s1_last  : s0_last;
  assign win_addr1   = sel1 ? s1_addr1 : s0_addr1;
  assign win_addr2   = sel1 ? s1_addr2 : s0_addr2;
  assign win_din1    = sel1 ? s1_din1  : s0_din1;
  assign win_din2    = sel1 ? s1_din2  : s0_din2;
  assign owned       = (state_q != ArbIdle);
  assign owner_valid = (state_q == ArbOwn1) ? s1_valid : s0_valid;

  wr_arb_burst_ctr #(
    .BURST_MAX (BURST_MAX),
    .HOLD_MAX  (HOLD_MAX)
  ) u_burst_ctr (
    .clk         (clk),
    .rst         (rst),
    .xfer        (xfer),
    .last        (win_last),
    .owned       (owned),
    .owner_valid (owner_valid),
    .burst_end   (burst_end),
    .hold_expire (hold_expire)
  );

  // Grant state and round-robin pointer; a burst end hands priority
  // to the side that did not just own the port.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (burst_end) begin
      state_d = ArbIdle;
      rr_d    = !sel1;
    end else if (xfer) begin
      state_d = sel1 ? ArbOwn1 : ArbOwn0;
    end
  end

  // BRAM-side payload, sticky collision flag and per-requester stats.
  always_comb begin
    we_d     = xfer;
    addr1_d  = xfer ? win_addr1 : addr1_q;
    addr2_d  = xfer ? win_addr2 : addr2_q;
    din1_d   = xfer ? win_din1  : din1_q;
    din2_d   = xfer ? win_din2  : din2_q;
    coll_d   = coll_q || (xfer && (win_addr1 == win_addr2));
    beats0_d = beats0_q + 16'(xfer0);
    beats1_d = beats1_q + 16'(xfer1);
  end

  // All arbiter and BRAM-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ArbIdle;
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      din1_q   <= '0;
      din2_q   <= '0;
      coll_q   <= 1'b0;
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
      coll_q   <= coll_d;
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
    end
  end

  assign we_BRAM32k     = we_q;
  assign addr_BRAM32k_1 = addr1_q;
  assign addr_BRAM32k_2 = addr2_q;
  assign din_BRAM32k_1  = din1_q;
  assign din_BRAM32k_2  = din2_q;
  assign owner          = state_q;
  assign collision_err  = coll_q;
  assign beats0         = beats0_q;
  assign beats1         = beats1_q;

endmodule

// File: tb/tb_bram32k_wr_arb.sv
// Randomized bench for bram32k_wr_arb against a burst-level reference model.
module tb_bram32k_wr_arb;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int BURST_MAX = 8;
  localparam int HOLD_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last;
  logic [AW-1:0] s0_addr1, s0_addr2, s1_addr1, s1_addr2;
  logic [DW-1:0] s0_din1, s0_din2, s1_din1, s1_din2;
  logic          we_BRAM32k, collision_err;
  logic [AW-1:0] addr_BRAM32k_1, addr_BRAM32k_2;
  logic [DW-1:0] din_BRAM32k_1, din_BRAM32k_2;
  logic [1:0]    owner;
  logic [15:0]   beats0, beats1;

  bram32k_wr_arb #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_last(s0_last),
    .s0_addr1(s0_addr1), .s0_addr2(s0_addr2), .s0_din1(s0_din1), .s0_din2(s0_din2),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_last(s1_last),
    .s1_addr1(s1_addr1), .s1_addr2(s1_addr2), .s1_din1(s1_din1), .s1_din2(s1_din2),
    .we_BRAM32k(we_BRAM32k), .addr_BRAM32k_1(addr_BRAM32k_1), .addr_BRAM32k_2(addr_BRAM32k_2),
    .din_BRAM32k_1(din_BRAM32k_1), .din_BRAM32k_2(din_BRAM32k_2), .owner(owner),
    .collision_err(collision_err), .beats0(beats0), .beats1(beats1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester stimulus: a beat is held stable until it is accepted.
  bit            gv[2], gl[2], acc[2];
  logic [AW-1:0] ga1[2], ga2[2];
  logic [DW-1:0] gd1[2], gd2[2];
  int            pv[2];
  int            pl, pc;

  // Reference model: which side owns the port, beats used and idle streak.
  int            m_own;   // -1 idle, else owning requester
  bit            m_rr;
  int            m_gcnt, m_idle;
  logic          e_we, e_coll;
  logic [AW-1:0] e_a1, e_a2;
  logic [DW-1:0] e_d1, e_d2;
  logic [15:0]   e_b0, e_b1;

  task automatic model_reset();
    m_own = -1; m_rr = 1'b0; m_gcnt = 0; m_idle = 0;
    e_we = 1'b0; e_coll = 1'b0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
    e_b0 = '0; e_b1 = '0;
  endtask

  task automatic refresh();
    for (int i = 0; i < 2; i++) begin
      if (!gv[i] || acc[i]) begin
        gv[i]  = ($urandom_range(99) < pv[i]);
        gl[i]  = ($urandom_range(99) < pl);
        ga1[i] = AW'($urandom_range(15));
        ga2[i] = ($urandom_range(99) < pc) ? ga1[i] : ga1[i] + AW'(12'h100);
        gd1[i] = {$urandom, $urandom};
        gd2[i] = {$urandom, $urandom};
      end
      acc[i] = 1'b0;
    end
    s0_valid = gv[0]; s0_last = gl[0]; s0_addr1 = ga1[0]; s0_addr2 = ga2[0];
    s0_din1 = gd1[0]; s0_din2 = gd2[0];
    s1_valid = gv[1]; s1_last = gl[1]; s1_addr1 = ga1[1]; s1_addr2 = ga2[1];
    s1_din1 = gd1[1]; s1_din2 = gd2[1];
  endtask

  // Check readies for the current inputs, then advance the model one edge.
  task automatic step();
    int win;
    bit fin;
    fin = 1'b0;
    if (rst) begin
      check("s0_ready_rst", s0_ready, 1'b0);
      check("s1_ready_rst", s1_ready, 1'b0);
      model_reset();
      return;
    end
    if (m_own >= 0)            win = m_own;
    else if (gv[0] && gv[1])   win = m_rr ? 1 : 0;
    else if (gv[0])            win = 0;
    else if (gv[1])            win = 1;
    else                       win = -1;
    check("s0_ready", s0_ready, win == 0);
    check("s1_ready", s1_ready, win == 1);
    e_we = 1'b0;
    if (win >= 0 && gv[win]) begin
      acc[win] = 1'b1;
      e_we = 1'b1;
      e_a1 = ga1[win]; e_a2 = ga2[win]; e_d1 = gd1[win]; e_d2 = gd2[win];
      if (ga1[win] == ga2[win]) e_coll = 1'b1;
      if (win == 0) e_b0 = e_b0 + 16'd1;
      else          e_b1 = e_b1 + 16'd1;
      m_gcnt++;
      m_idle = 0;
      if (gl[win] || m_gcnt >= BURST_MAX) fin = 1'b1;
      else m_own = win;
    end else if (m_own >= 0) begin
      m_idle++;
      if (m_idle >= HOLD_MAX) fin = 1'b1;
    end
    if (fin) begin
      m_rr = (win == 0);
      m_own = -1; m_gcnt = 0; m_idle = 0;
    end
  endtask

  task automatic post_check();
    check("we", we_BRAM32k, e_we);
    check("addr1", addr_BRAM32k_1, e_a1);
    check("addr2", addr_BRAM32k_2, e_a2);
    check("din1", din_BRAM32k_1, e_d1);
    check("din2", din_BRAM32k_2, e_d2);
    check("owner", owner, (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00);
    check("collision", collision_err, e_coll);
    check("beats0", beats0, e_b0);
    check("beats1", beats1, e_b1);
  endtask

  task automatic cycle();
    refresh();
    #1;
    step();
    @(posedge clk);
    #1;
    post_check();
  endtask

  task automatic phase(input int n, input int v0, input int v1, input int l, input int c);
    pv[0] = v0; pv[1] = v1; pl = l; pc = c;
    repeat (n) cycle();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      gv[i] = 1'b0; gl[i] = 1'b0; acc[i] = 1'b0;
    end
    pv[0] = 100; pv[1] = 100; pl = 50; pc = 0;
    model_reset();
    rst = 1'b1;
    #1;
    // reset with both requesters offering beats
    repeat (3) cycle();
    rst = 1'b0;
    phase(150, 60, 0, 30, 0);     // s0 alone, short bursts
    phase(200, 100, 100, 50, 0);  // back-to-back alternation
    phase(250, 100, 100, 0, 0);   // endless streams, cap forces handover
    phase(250, 30, 90, 10, 0);    // sparse s0 exercises hold expiry
    phase(100, 100, 100, 20, 0);
    rst = 1'b1;                   // reset mid-burst
    repeat (2) cycle();
    rst = 1'b0;
    phase(250, 70, 70, 25, 20);   // collisions, sticky flag
    phase(200, 80, 40, 15, 5);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    phase(100, 90, 90, 10, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
